gelato_fetch_arbiter: RTL and testbench

GELATO_FETCH_ARBITER -- requirements
Module: gelato_fetch_arbiter

---
 rtl/gelato_fetch_arbiter.sv | 159 +++++++++++++++
 tb/tb_gelato_fetch_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_fetch_arbiter.sv
// Round-robin instruction-fetch arbiter.
// Picks one eligible warp per cycle and presents it on a single registered
// valid/ready request slot. Each warp may have at most one fetch outstanding,
// tracked by a per-warp in-flight bit that is set on grant and cleared by a
// response or a flush.
module gelato_fetch_arbiter #(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned WID_WIDTH = $clog2(NUM_WARPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic [NUM_WARPS-1:0]          warp_active,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
  output logic                          fetch_valid,
  input  logic                          fetch_ready,
  output logic [WID_WIDTH-1:0]          fetch_warp_id,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  input  logic                          resp_valid,
  input  logic [WID_WIDTH-1:0]          resp_warp_id,
  input  logic                          flush_valid,
  input  logic [WID_WIDTH-1:0]          flush_warp_id,
  output logic [NUM_WARPS-1:0]          inflight
);

  // Warp count widened by one bit so ids and sums can be compared against it.
  localparam logic [WID_WIDTH:0]   NumWarpsW = (WID_WIDTH + 1)'(NUM_WARPS);
  // Pointer resets to the last warp so that warp 0 wins the first search.
  localparam logic [WID_WIDTH-1:0] RrReset   = WID_WIDTH'(NUM_WARPS - 1);

  // Registered state
  logic                 valid_q,    valid_d;
  logic [WID_WIDTH-1:0] wid_q,      wid_d;
  logic [PC_WIDTH-1:0]  pc_q,       pc_d;
  logic [NUM_WARPS-1:0] inflight_q, inflight_d;
  logic [WID_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;

  // Decoded control
  logic                 resp_ok;
  logic                 flush_ok;
  logic [NUM_WARPS-1:0] resp_clr;
  logic [NUM_WARPS-1:0] flush_clr;
  logic                 slot_flush;
  logic                 accept;
  logic                 slot_free;
  logic                 load_en;
  logic [NUM_WARPS-1:0] eligible;
  logic                 grant_found;
  logic [WID_WIDTH-1:0] grant_id;
  logic [WID_WIDTH:0]   cand;
  logic                 grant;
  logic [NUM_WARPS-1:0] grant_onehot;

  // Per-warp PC view of the flat input bus
  logic [PC_WIDTH-1:0]  pc_arr [NUM_WARPS];

  for (genvar i = 0; i < NUM_WARPS; i++) begin : g_pc_unpack
    assign pc_arr[i] = warp_pc[i*PC_WIDTH +: PC_WIDTH];
  end

  // Qualify response/flush: ignored while stalled or when the id is out of range.
  always_comb begin
    resp_ok   = rdy & resp_valid  & ({1'b0, resp_warp_id}  < NumWarpsW);
    flush_ok  = rdy & flush_valid & ({1'b0, flush_warp_id} < NumWarpsW);
    resp_clr  = '0;
    flush_clr = '0;
    if (resp_ok) begin
      resp_clr[resp_warp_id] = 1'b1;
    end
    if (flush_ok) begin
      flush_clr[flush_warp_id] = 1'b1;
    end
  end

  // Slot bookkeeping: a flush of the warp sitting in the slot cancels it, even
  // if the fetch unit is ready in the same cycle.
  always_comb begin
    slot_flush = valid_q & flush_ok & (flush_warp_id == wid_q);
    accept     = rdy & valid_q & fetch_ready & ~slot_flush;
    slot_free  = ~valid_q | accept;
    load_en    = rdy & slot_free & ~slot_flush;
    // A warp being flushed this cycle is not granted; the flush wins.
    eligible   = warp_active & ~inflight_q & ~flush_clr;
  end

  // Round-robin search starting one past the last grant, wrapping at NUM_WARPS.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
      cand = {1'b0, rr_ptr_q} + k[WID_WIDTH:0];
      if (cand >= NumWarpsW) begin
        cand = cand - NumWarpsW;
      end
      if (!grant_found && eligible[cand[WID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[WID_WIDTH-1:0];
      end
    end
  end

  // One-hot form of the winning warp for the in-flight set.
  always_comb begin
    grant        = load_en & grant_found;
    grant_onehot = '0;
    if (grant) begin
      grant_onehot[grant_id] = 1'b1;
    end
  end

  // Next-state for the request slot, in-flight flags and round-robin pointer.
  always_comb begin
    valid_d    = valid_q;
    wid_d      = wid_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    rr_ptr_d   = rr_ptr_q;
    if (rdy) begin
      if (slot_flush) begin
        valid_d = 1'b0;
      end else if (slot_free) begin
        valid_d = grant_found;
        if (grant_found) begin
          wid_d = grant_id;
          pc_d  = pc_arr[grant_id];
        end
      end
      inflight_d = (inflight_q & ~(resp_clr | flush_clr)) | grant_onehot;
      if (grant) begin
        rr_ptr_d = grant_id;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      wid_q      <= '0;
      pc_q       <= '0;
      inflight_q <= '0;
      rr_ptr_q   <= RrReset;
    end else begin
      valid_q    <= valid_d;
      wid_q      <= wid_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign fetch_valid   = valid_q;
  assign fetch_warp_id = wid_q;
  assign fetch_pc      = pc_q;
  assign inflight      = inflight_q;

endmodule

// File: tb/tb_gelato_fetch_arbiter.sv
// Bench for gelato_fetch_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_gelato_fetch_arbiter;

  localparam int N  = 8;
  localparam int PW = 32;
  localparam int WW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rdy;
  logic [N-1:0]    warp_active;
  logic [N*PW-1:0] warp_pc;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [WW-1:0]   fetch_warp_id;
  logic [PW-1:0]   fetch_pc;
  logic            resp_valid;
  logic [WW-1:0]   resp_warp_id;
  logic            flush_valid;
  logic [WW-1:0]   flush_warp_id;
  logic [N-1:0]    inflight;

  always #5 clk = ~clk;

  gelato_fetch_arbiter #(
    .NUM_WARPS(N),
    .PC_WIDTH (PW),
    .WID_WIDTH(WW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .warp_active  (warp_active),
    .warp_pc      (warp_pc),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_warp_id(fetch_warp_id),
    .fetch_pc     (fetch_pc),
    .resp_valid   (resp_valid),
    .resp_warp_id (resp_warp_id),
    .flush_valid  (flush_valid),
    .flush_warp_id(flush_warp_id),
    .inflight     (inflight)
  );

  typedef struct packed {
    logic          v;
    logic          chk;
    logic [WW-1:0] id;
    logic [PW-1:0] pc;
    logic [N-1:0]  infl;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: abstract state of the arbiter
  bit            m_v    = 0;
  int            m_id   = 0;
  logic [PW-1:0] m_pc   = '0;
  bit   [N-1:0]  m_infl = '0;
  int            m_ptr  = N - 1;
  int            outst[$];  // accepted fetches awaiting a response

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void outst_remove(int id);
    for (int i = 0; i < outst.size(); i++) begin
      if (outst[i] == id) begin
        outst.delete(i);
        break;
      end
    end
  endfunction

  // Apply the current inputs to the model for one clock edge.
  function automatic void model_step();
    bit [N-1:0] elig;
    bit         hit;
    bit         acc;
    int         g;
    int         idx;
    if (!rst_n) begin
      m_v = 0; m_id = 0; m_pc = '0; m_infl = '0; m_ptr = N - 1;
      outst.delete();
      return;
    end
    if (!rdy) return;
    hit  = m_v && flush_valid && (int'(flush_warp_id) == m_id);
    acc  = m_v && fetch_ready && !hit;
    elig = warp_active & ~m_infl;
    if (flush_valid) elig[flush_warp_id] = 1'b0;
    if (acc) outst.push_back(m_id);
    if (resp_valid && m_infl[resp_warp_id]) begin
      m_infl[resp_warp_id] = 1'b0;
      outst_remove(int'(resp_warp_id));
    end
    if (flush_valid) begin
      m_infl[flush_warp_id] = 1'b0;
      outst_remove(int'(flush_warp_id));
    end
    if (hit) begin
      m_v = 0;
    end else if (!m_v || acc) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && elig[idx]) g = idx;
      end
      if (g < 0) begin
        m_v = 0;
      end else begin
        m_v       = 1;
        m_id      = g;
        m_pc      = warp_pc[g*PW +: PW];
        m_infl[g] = 1'b1;
        m_ptr     = g;
      end
    end
  endfunction

  // Called at a negedge with inputs set: predict, queue, advance one cycle.
  task automatic tick();
    exp_t e;
    model_step();
    e.v    = m_v;
    e.chk  = m_v || !rst_n;
    e.id   = WW'(m_id);
    e.pc   = m_pc;
    e.infl = m_infl;
    expq.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare registered outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("mon_valid", 64'(fetch_valid), 64'(e.v));
        check("mon_inflight", 64'(inflight), 64'(e.infl));
        if (e.chk) begin
          check("mon_warp_id", 64'(fetch_warp_id), 64'(e.id));
          check("mon_pc", 64'(fetch_pc), 64'(e.pc));
        end
      end
    end
  end

  // Quiesce: stop new grants, accept the slot, respond to every outstanding warp.
  task automatic drain();
    rdy         = 1'b1;
    warp_active = '0;
    fetch_ready = 1'b1;
    flush_valid = 1'b0;
    for (int i = 0; i < 40 && (m_v || outst.size() > 0); i++) begin
      resp_valid = (outst.size() > 0);
      if (resp_valid) resp_warp_id = WW'(outst[0]);
      tick();
    end
    resp_valid = 1'b0;
    tick();
    check("drain_idle_valid", 64'(fetch_valid), 64'(0));
    check("drain_idle_inflight", 64'(inflight), 64'(0));
  endtask

  task automatic rand_inputs();
    int id;
    rdy         = ($urandom_range(0, 9) != 0);
    warp_active = N'($urandom());
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < N; i++) warp_pc[i*PW +: PW] = PW'($urandom());
    end
    fetch_ready = ($urandom_range(0, 9) < 6);
    resp_valid  = 1'b0;
    flush_valid = 1'b0;
    if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
      resp_valid   = 1'b1;
      resp_warp_id = WW'(outst[$urandom_range(0, outst.size() - 1)]);
    end else if ($urandom_range(0, 9) == 0) begin
      // Stray response for a warp with nothing outstanding: must be ignored.
      id = $urandom_range(0, N - 1);
      if (!m_infl[id]) begin
        resp_valid   = 1'b1;
        resp_warp_id = WW'(id);
      end
    end
    if ($urandom_range(0, 19) == 0) begin
      flush_valid   = 1'b1;
      flush_warp_id = WW'($urandom_range(0, N - 1));
    end
  endtask

  initial begin
    bit            sv_v;
    int            sv_id;
    logic [PW-1:0] sv_pc;
    bit   [N-1:0]  sv_infl;
    int            rid;

    rst_n = 1'b0; rdy = 1'b1; warp_active = '0; warp_pc = '0; fetch_ready = 1'b0;
    resp_valid = 1'b0; resp_warp_id = '0; flush_valid = 1'b0; flush_warp_id = '0;
    for (int i = 0; i < N; i++) warp_pc[i*PW +: PW] = PW'(32'h1000 + i * 16);
    @(negedge clk);
    tick();
    tick();
    check("reset_valid", 64'(fetch_valid), 64'(0));
    check("reset_id", 64'(fetch_warp_id), 64'(0));
    check("reset_pc", 64'(fetch_pc), 64'(0));
    check("reset_inflight", 64'(inflight), 64'(0));

    // All warps active, fetch unit always ready: grants 0..7 back to back.
    rst_n = 1'b1;
    warp_active = '1;
    fetch_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      tick();
      check("seq_valid", 64'(fetch_valid), 64'(1));
      check("seq_id", 64'(fetch_warp_id), 64'(k));
      check("seq_pc", 64'(fetch_pc), 64'(32'h1000 + k * 16));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("seq_idle", 64'(fetch_valid), 64'(0));
    end
    check("seq_all_inflight", 64'(inflight), 64'(8'hFF));

    // Response frees warp 3 next cycle; regrant only one cycle after that.
    resp_valid = 1'b1; resp_warp_id = 3'd3;
    tick();
    resp_valid = 1'b0;
    check("resp_clear", 64'(inflight[3]), 64'(0));
    check("resp_no_early_grant", 64'(fetch_valid), 64'(0));
    tick();
    check("resp_regrant_valid", 64'(fetch_valid), 64'(1));
    check("resp_regrant_id", 64'(fetch_warp_id), 64'(3));
    drain();

    // Backpressure: warp 0 held with its original PC; then round-robin to warp 2.
    warp_active = 8'h05;
    fetch_ready = 1'b0;
    tick();
    check("hold_first_id", 64'(fetch_warp_id), 64'(0));
    for (int k = 0; k < 3; k++) begin
      warp_pc[0 +: PW] = PW'(32'hDEAD_0000 + k);
      tick();
      check("hold_valid", 64'(fetch_valid), 64'(1));
      check("hold_id", 64'(fetch_warp_id), 64'(0));
      check("hold_pc", 64'(fetch_pc), 64'(32'h1000));
    end
    fetch_ready = 1'b1;
    tick();
    check("after_hold_id", 64'(fetch_warp_id), 64'(2));
    check("after_hold_pc", 64'(fetch_pc), 64'(32'h1020));
    drain();

    // Flush of the warp in an unaccepted slot overrides a same-cycle ready.
    warp_active = 8'h20;
    fetch_ready = 1'b0;
    tick();
    check("flush_setup_id", 64'(fetch_warp_id), 64'(5));
    flush_valid = 1'b1; flush_warp_id = 3'd5; fetch_ready = 1'b1; warp_active = '0;
    tick();
    flush_valid = 1'b0;
    check("flush_drop_valid", 64'(fetch_valid), 64'(0));
    check("flush_clear", 64'(inflight[5]), 64'(0));
    tick();
    check("flush_no_reissue", 64'(fetch_valid), 64'(0));
    // Flush of a warp that would otherwise be granted this cycle: no grant.
    warp_active = 8'h20; flush_valid = 1'b1; flush_warp_id = 3'd5;
    tick();
    flush_valid = 1'b0;
    check("flush_vs_grant", 64'(fetch_valid), 64'(0));
    tick();
    check("flush_then_grant", 64'(fetch_warp_id), 64'(5));
    drain();

    // Stall: rdy low freezes everything, including pending resp/flush/handshake.
    warp_active = '1;
    fetch_ready = 1'b1;
    tick();
    tick();
    fetch_ready = 1'b0;
    tick();
    sv_v = m_v; sv_id = m_id; sv_pc = m_pc; sv_infl = m_infl;
    rid = (outst.size() > 0) ? outst[0] : 0;
    rdy = 1'b0; fetch_ready = 1'b1;
    resp_valid = (outst.size() > 0); resp_warp_id = WW'(rid);
    flush_valid = 1'b1; flush_warp_id = WW'(sv_id);
    for (int i = 0; i < N; i++) warp_pc[i*PW +: PW] = PW'(32'hBEEF_0000 + i);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_valid", 64'(fetch_valid), 64'(sv_v));
      check("stall_id", 64'(fetch_warp_id), 64'(sv_id));
      check("stall_pc", 64'(fetch_pc), 64'(sv_pc));
      check("stall_inflight", 64'(inflight), 64'(sv_infl));
    end
    rdy = 1'b1; flush_valid = 1'b0;
    tick();
    resp_valid = 1'b0;
    drain();

    // Asynchronous reset while a request is pending.
    warp_active = '1;
    fetch_ready = 1'b0;
    tick();
    tick();
    check("prereset_valid", 64'(fetch_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(fetch_valid), 64'(0));
    check("async_id", 64'(fetch_warp_id), 64'(0));
    check("async_pc", 64'(fetch_pc), 64'(0));
    check("async_inflight", 64'(inflight), 64'(0));
    fetch_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_id", 64'(fetch_warp_id), 64'(0));
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
